crossbar_cmd_arbiter: RTL and testbench

CROSSBAR_CMD_ARBITER -- requirements
Module: crossbar_cmd_arbiter

---
 rtl/crossbar_cmd_arbiter.sv | 97 +++++++++
 tb/tb_crossbar_cmd_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/crossbar_cmd_arbiter.sv
// Per-destination round-robin arbiter that turns source requests into registered
// one-hot crossbar commands, with a combinational ready and a saturating conflict counter.
module crossbar_cmd_arbiter #(
    parameter int DATA_WIDTH      = 32,
    parameter int NUM_INPUT_DATA  = 16,
    parameter int NUM_OUTPUT_DATA = 16,
    parameter int DEST_WIDTH      = $clog2(NUM_OUTPUT_DATA)
) (
    input  logic                                      CLK,
    input  logic                                      rst,
    input  logic                                      i_en,
    input  logic [NUM_INPUT_DATA-1:0]                 i_valid,
    input  logic [NUM_INPUT_DATA*DATA_WIDTH-1:0]      i_data_bus,
    input  logic [NUM_INPUT_DATA*DEST_WIDTH-1:0]      i_dest,
    output logic [NUM_INPUT_DATA-1:0]                 o_ready,
    output logic [NUM_INPUT_DATA-1:0]                 o_valid,
    output logic [NUM_INPUT_DATA*DATA_WIDTH-1:0]      o_data_bus,
    output logic [NUM_INPUT_DATA*NUM_OUTPUT_DATA-1:0] o_cmd,
    output logic [15:0]                               o_conflict_cnt
);

    localparam int NI = NUM_INPUT_DATA;
    localparam int NO = NUM_OUTPUT_DATA;

    logic [NI-1:0]            grant;
    logic [NI-1:0]            valid_q;
    logic [NI*DATA_WIDTH-1:0] data_d, data_q;
    logic [NI*NO-1:0]         cmd_d, cmd_q;
    logic [DEST_WIDTH-1:0]    ptr_d [NO];
    logic [DEST_WIDTH-1:0]    ptr_q [NO];
    logic [15:0]              cnt_q;
    logic                     conflict;
    logic                     found;
    int                       src;

    // Each output scans sources starting at its pointer; first hit wins.
    // Reset suppresses every request so nothing is accepted during rst.
    always_comb begin
        grant = '0;
        cmd_d = '0;
        found = 1'b0;
        src   = 0;
        for (int j = 0; j < NO; j++) begin
            ptr_d[j] = ptr_q[j];
            found    = 1'b0;
            for (int k = 0; k < NI; k++) begin
                src = (int'(ptr_q[j]) + k) % NI;
                if (!found && i_en && !rst && i_valid[src] &&
                    i_dest[src*DEST_WIDTH +: DEST_WIDTH] == DEST_WIDTH'(j)) begin
                    found              = 1'b1;
                    grant[src]         = 1'b1;
                    cmd_d[src*NO + j]  = 1'b1;
                    ptr_d[j]           = DEST_WIDTH'((src + 1) % NI);
                end
            end
        end
    end

    always_comb begin
        data_d = '0;
        for (int i = 0; i < NI; i++) begin
            data_d[i*DATA_WIDTH +: DATA_WIDTH] =
                grant[i] ? i_data_bus[i*DATA_WIDTH +: DATA_WIDTH] : '0;
        end
    end

    assign conflict = i_en && (|(i_valid & ~grant));

    always_ff @(posedge CLK) begin
        if (rst) begin
            valid_q <= '0;
            data_q  <= '0;
            cmd_q   <= '0;
            cnt_q   <= '0;
            for (int j = 0; j < NO; j++) begin
                ptr_q[j] <= '0;
            end
        end else if (i_en) begin
            valid_q <= grant;
            data_q  <= data_d;
            cmd_q   <= cmd_d;
            for (int j = 0; j < NO; j++) begin
                ptr_q[j] <= ptr_d[j];
            end
            if (conflict && cnt_q != 16'hFFFF) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end

    assign o_ready        = grant;
    assign o_valid        = valid_q;
    assign o_data_bus     = data_q;
    assign o_cmd          = cmd_q;
    assign o_conflict_cnt = cnt_q;

endmodule

// File: tb/tb_crossbar_cmd_arbiter.sv
// Directed bench for crossbar_cmd_arbiter: a vector table for the main flow plus
// short hand sequences for pointer wrap, enable freeze and mid-stream reset.
module tb_crossbar_cmd_arbiter;

    logic           CLK = 1'b0;
    logic           rst;
    logic           i_en;
    logic [15:0]    i_valid;
    logic [511:0]   i_data_bus;
    logic [63:0]    i_dest;
    logic [15:0]    o_ready;
    logic [15:0]    o_valid;
    logic [511:0]   o_data_bus;
    logic [255:0]   o_cmd;
    logic [15:0]    o_conflict_cnt;

    int n_total  = 0;
    int n_passed = 0;

    logic [15:0]  prev_valid;
    logic [255:0] prev_cmd;
    logic [511:0] prev_data;

    typedef struct {
        logic        en;
        logic [15:0] valid;
        logic [63:0] dest;
        logic [15:0] exp_ready;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs [9];

    crossbar_cmd_arbiter dut (
        .CLK            (CLK),
        .rst            (rst),
        .i_en           (i_en),
        .i_valid        (i_valid),
        .i_data_bus     (i_data_bus),
        .i_dest         (i_dest),
        .o_ready        (o_ready),
        .o_valid        (o_valid),
        .o_data_bus     (o_data_bus),
        .o_cmd          (o_cmd),
        .o_conflict_cnt (o_conflict_cnt)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] word(int i);
        return (i == 0) ? 32'hA5A5A5A5 : 32'hC0DE0000 + 32'(i);
    endfunction

    function automatic logic [255:0] mk_cmd(logic [15:0] r, logic [63:0] d);
        logic [255:0] c = '0;
        for (int i = 0; i < 16; i++)
            if (r[i]) c[i*16 + int'(d[i*4 +: 4])] = 1'b1;
        return c;
    endfunction

    function automatic logic [511:0] mk_data(logic [15:0] r);
        logic [511:0] m = '0;
        for (int i = 0; i < 16; i++)
            if (r[i]) m[i*32 +: 32] = word(i);
        return m;
    endfunction

    task automatic check(string name, logic [511:0] act, logic [511:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            n_passed++;
    endtask

    // One arbitration cycle: check combinational ready, then the registered result.
    task automatic cycle(string name, logic en, logic [15:0] valid, logic [63:0] dest,
                         logic [15:0] exp_ready, logic [15:0] exp_cnt);
        logic [15:0]  ev;
        logic [255:0] ec;
        logic [511:0] ed;
        i_en    = en;
        i_valid = valid;
        i_dest  = dest;
        #1;
        check({name, ".ready"}, 512'(o_ready), 512'(exp_ready));
        @(posedge CLK);
        #1;
        if (en) begin
            ev = exp_ready;
            ec = mk_cmd(exp_ready, dest);
            ed = mk_data(exp_ready);
        end else begin
            ev = prev_valid;
            ec = prev_cmd;
            ed = prev_data;
        end
        check({name, ".valid"}, 512'(o_valid), 512'(ev));
        check({name, ".cmd"},   512'(o_cmd),   512'(ec));
        check({name, ".data"},  o_data_bus,    ed);
        check({name, ".cnt"},   512'(o_conflict_cnt), 512'(exp_cnt));
        prev_valid = ev;
        prev_cmd   = ec;
        prev_data  = ed;
    endtask

    initial begin
        //            en    valid     dest                    ready     cnt
        vecs[0] = '{1'b1, 16'h0001, 64'h0000_0000_0000_0005, 16'h0001, 16'd0};
        vecs[1] = '{1'b1, 16'h0089, 64'h0000_0000_2000_2002, 16'h0001, 16'd1};
        vecs[2] = '{1'b1, 16'h0088, 64'h0000_0000_2000_2002, 16'h0008, 16'd2};
        vecs[3] = '{1'b1, 16'h0080, 64'h0000_0000_2000_2002, 16'h0080, 16'd2};
        vecs[4] = '{1'b1, 16'hFFFF, 64'h0123_4567_89AB_CDEF, 16'hFFFF, 16'd2};
        vecs[5] = '{1'b0, 16'h0003, 64'h0000_0000_0000_0011, 16'h0000, 16'd2};
        vecs[6] = '{1'b1, 16'h0003, 64'h0000_0000_0000_0011, 16'h0001, 16'd3};
        vecs[7] = '{1'b1, 16'h0002, 64'h0000_0000_0000_0011, 16'h0002, 16'd3};
        vecs[8] = '{1'b1, 16'h0000, 64'h0000_0000_0000_0011, 16'h0000, 16'd3};

        for (int i = 0; i < 16; i++) i_data_bus[i*32 +: 32] = word(i);

        // Reset with every source requesting: nothing may be accepted.
        rst     = 1'b1;
        i_en    = 1'b1;
        i_valid = 16'hFFFF;
        i_dest  = 64'h0123_4567_89AB_CDEF;
        #1;
        check("rst.ready", 512'(o_ready), 512'(16'h0));
        @(posedge CLK);
        @(posedge CLK);
        #1;
        check("rst.valid", 512'(o_valid), 512'(16'h0));
        check("rst.cmd",   512'(o_cmd),   '0);
        check("rst.data",  o_data_bus,    '0);
        check("rst.cnt",   512'(o_conflict_cnt), 512'(16'h0));
        rst        = 1'b0;
        prev_valid = '0;
        prev_cmd   = '0;
        prev_data  = '0;

        for (int v = 0; v < 9; v++) begin
            cycle($sformatf("vec%0d", v), vecs[v].en, vecs[v].valid, vecs[v].dest,
                  vecs[v].exp_ready, vecs[v].exp_cnt);
            if (v == 0) check("vec0.ptr5", 512'(dut.ptr_q[5]), 512'(4'd1));
        end

        // Pointer wrap on dest 0: source 15 grant sends ptr[0] back to 0.
        cycle("wrap.s3",  1'b1, 16'h0008, 64'h0, 16'h0008, 16'd3);
        cycle("wrap.s15", 1'b1, 16'h8000, 64'h0, 16'h8000, 16'd3);
        check("wrap.ptr0", 512'(dut.ptr_q[0]), 512'(4'd0));
        cycle("wrap.both", 1'b1, 16'h8001, 64'h0, 16'h0001, 16'd4);

        // Enable freeze: outputs and ptr[7] hold across four disabled cycles.
        cycle("frz.grant", 1'b1, 16'h0014, 64'h0007_0700, 16'h0004, 16'd5);
        for (int c = 0; c < 4; c++)
            cycle($sformatf("frz.off%0d", c), 1'b0, 16'h0014, 64'h0007_0700, 16'h0000, 16'd5);
        cycle("frz.resume", 1'b1, 16'h0014, 64'h0007_0700, 16'h0010, 16'd6);

        // Mid-stream reset with four pending requests on dest 3.
        cycle("mrst.pre", 1'b1, 16'h1222, 64'h0003_0030_0030_0030, 16'h0002, 16'd7);
        rst = 1'b1;
        #1;
        check("mrst.ready", 512'(o_ready), 512'(16'h0));
        @(posedge CLK);
        #1;
        check("mrst.valid", 512'(o_valid), 512'(16'h0));
        check("mrst.cmd",   512'(o_cmd),   '0);
        check("mrst.data",  o_data_bus,    '0);
        check("mrst.cnt",   512'(o_conflict_cnt), 512'(16'h0));
        rst        = 1'b0;
        prev_valid = '0;
        prev_cmd   = '0;
        prev_data  = '0;
        cycle("mrst.post", 1'b1, 16'h1222, 64'h0003_0030_0030_0030, 16'h0002, 16'd1);

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule
